perm_in_buf: RTL and testbench

Store-and-forward block buffer between the NOC interface's device-side push port (pushin/firstin/din/stopin) and the permutation block's input. It accepts 64-bit lanes framed into 25-word blocks (one 5x5 state) and releases a block downstream only once all 25 words are held. Malformed partial blocks are discarded without ever reaching the permutation. It decouples NOC byte-serial arrival jitter from the permutation's stall behaviour.

---
 rtl/perm_in_buf_if.sv | 18 +
 rtl/perm_in_buf.sv | 118 +++++++++++
 tb/tb_perm_in_buf.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/perm_in_buf_if.sv
// rtl/perm_in_buf_if.sv - push/first/data/stop word stream between NOC, buffer and permutation
//
// Signals (named from the producer's point of view):
//   push   word valid, driven by master
//   first  marks word 0 of a block, qualified by push, driven by master
//   data   64-bit word, driven by master
//   stop   backpressure, driven by slave; a word is not taken while high
interface perm_in_buf_if #(
   parameter int W = 64
);
   logic         push;
   logic         first;
   logic [W-1:0] data;
   logic         stop;

   modport master (output push, output first, output data, input stop);
   modport slave  (input push, input first, input data, output stop);
endinterface

// File: rtl/perm_in_buf.sv
// rtl/perm_in_buf.sv - store-and-forward 25-word block buffer feeding the permutation
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset, drops every buffered word
//   up       slave stream from the NOC push port (pushin/firstin/din/stopin)
//   dn       master stream to the permutation (pushout/firstout/dout/stopout)
//   blk_err  one-cycle pulse after an accepted word that breaks block framing
//
// Words of an open block are written speculatively past cptr; only the last
// word of a block moves cptr, so the read side never sees a partial block and
// an aborted block is discarded simply by rewinding wptr to cptr.
module perm_in_buf #(
   parameter int DEPTH = 64,
   parameter int WORDS = 25
) (
   input  logic          clk,
   input  logic          reset,
   perm_in_buf_if.slave  up,
   perm_in_buf_if.master dn,
   output logic          blk_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WORDS);

   typedef logic [AW:0] ptr_t;

   localparam ptr_t       FULL_OCC = ptr_t'(DEPTH);
   localparam logic [CW-1:0] LAST_W = CW'(WORDS - 1);

   logic [63:0]   mem [DEPTH];
   ptr_t          wptr, cptr, rptr;
   ptr_t          wptr_nx, cptr_nx;
   logic [CW-1:0] wcnt, wcnt_nx;
   logic [CW-1:0] rcnt;
   ptr_t          occ;
   logic          full;
   logic          accept;
   logic          drain;
   logic          wr_en;
   ptr_t          wr_ptr;
   logic          err_nx;

   // Occupancy counts uncommitted words too, so a long partial block can fill
   // the buffer and stall upstream even when nothing is committed.
   assign occ    = wptr - rptr;
   assign full   = (occ == FULL_OCC);
   assign accept = up.push & ~full;
   assign drain  = dn.push & ~dn.stop;

   assign up.stop  = full;
   assign dn.push  = (cptr != rptr);
   assign dn.first = dn.push & (rcnt == '0);
   assign dn.data  = dn.push ? mem[rptr[AW-1:0]] : 64'h0;

   always_comb begin
      wr_en   = 1'b0;
      wr_ptr  = wptr;
      wptr_nx = wptr;
      cptr_nx = cptr;
      wcnt_nx = wcnt;
      err_nx  = 1'b0;
      if (accept) begin
         if (up.first) begin
            wr_en   = 1'b1;
            wcnt_nx = CW'(1);
            if (wcnt == '0) begin
               wptr_nx = wptr + 1'b1;
            end else begin
               // Restart inside an open block: overwrite from the commit point.
               wr_ptr  = cptr;
               wptr_nx = cptr + 1'b1;
               err_nx  = 1'b1;
            end
         end else if (wcnt == '0) begin
            // Orphan word with no open block is dropped.
            err_nx = 1'b1;
         end else if (wcnt == LAST_W) begin
            wr_en   = 1'b1;
            wptr_nx = wptr + 1'b1;
            cptr_nx = wptr + 1'b1;
            wcnt_nx = '0;
         end else begin
            wr_en   = 1'b1;
            wptr_nx = wptr + 1'b1;
            wcnt_nx = wcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= up.data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr    <= '0;
         cptr    <= '0;
         rptr    <= '0;
         wcnt    <= '0;
         rcnt    <= '0;
         blk_err <= 1'b0;
      end else begin
         wptr    <= wptr_nx;
         cptr    <= cptr_nx;
         wcnt    <= wcnt_nx;
         blk_err <= err_nx;
         if (drain) begin
            rptr <= rptr + 1'b1;
            rcnt <= (rcnt == LAST_W) ? '0 : rcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_perm_in_buf.sv
// tb/tb_perm_in_buf.sv - randomized scoreboard bench for perm_in_buf
module tb_perm_in_buf;

   localparam int DEPTH = 64;
   localparam int WORDS = 25;

   typedef struct {
      logic [63:0] d;
      bit          f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic blk_err;
   int   stop_mode = 0;

   perm_in_buf_if up_if ();
   perm_in_buf_if dn_if ();

   perm_in_buf #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .up      (up_if),
      .dn      (dn_if),
      .blk_err (blk_err)
   );

   always #5 clk = ~clk;

   exp_t        exp_q [$];
   logic [63:0] part_q [$];
   bit          err_exp = 1'b0;
   int          accepts = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endfunction

   // Reference model: a block is a list of words that becomes visible only
   // once it holds WORDS entries; anything else is discarded.
   function automatic void model_accept(bit f, logic [63:0] d);
      accepts++;
      if (f) begin
         if (part_q.size() != 0) err_exp = 1'b1;
         part_q.delete();
         part_q.push_back(d);
      end else if (part_q.size() == 0) begin
         err_exp = 1'b1;
      end else begin
         part_q.push_back(d);
      end
      if (part_q.size() == WORDS) begin
         for (int i = 0; i < WORDS; i++) begin
            exp_t e;
            e.d = part_q[i];
            e.f = (i == 0);
            exp_q.push_back(e);
         end
         part_q.delete();
      end
   endfunction

   // Monitor: compares at the falling edge, then books the transfers that the
   // next rising edge will perform.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         part_q.delete();
         err_exp = 1'b0;
      end else begin
         chk("blk_err", 64'(blk_err), 64'(err_exp));
         err_exp = 1'b0;
         chk("stopin", 64'(up_if.stop), 64'((exp_q.size() + part_q.size()) == DEPTH));
         chk("pushout", 64'(dn_if.push), 64'(exp_q.size() != 0));
         if (dn_if.push && exp_q.size() != 0) begin
            chk("dout", dn_if.data, exp_q[0].d);
            chk("firstout", 64'(dn_if.first), 64'(exp_q[0].f));
            if (!dn_if.stop) void'(exp_q.pop_front());
         end else begin
            chk("dout_idle", dn_if.data, 64'h0);
            chk("firstout_idle", 64'(dn_if.first), 64'h0);
         end
         if (up_if.push && !up_if.stop) model_accept(up_if.first, up_if.data);
      end
   end

   always @(posedge clk) begin
      #1;
      case (stop_mode)
         0:       dn_if.stop = 1'b0;
         1:       dn_if.stop = 1'b1;
         2:       dn_if.stop = ~dn_if.stop;
         default: dn_if.stop = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic push_word(bit f, logic [63:0] d);
      int n = 0;
      up_if.push  = 1'b1;
      up_if.first = f;
      up_if.data  = d;
      forever begin
         @(posedge clk);
         if (!up_if.stop) break;
         n++;
         if (n > 3000) begin
            chk("push_timeout", 64'(n), 64'h0);
            break;
         end
      end
      #1;
      up_if.push  = 1'b0;
      up_if.first = 1'b0;
      up_if.data  = 64'h0;
   endtask

   task automatic send_block(int n, logic [63:0] base);
      for (int i = 0; i < n; i++) push_word(i == 0, base + 64'(i));
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      chk("rst_pushout", 64'(dn_if.push), 64'h0);
      chk("rst_stopin", 64'(up_if.stop), 64'h0);
      chk("rst_blk_err", 64'(blk_err), 64'h0);
      chk("rst_firstout", 64'(dn_if.first), 64'h0);
      chk("rst_dout", dn_if.data, 64'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int acc0;
      int n;
      up_if.push  = 1'b0;
      up_if.first = 1'b0;
      up_if.data  = 64'h0;
      dn_if.stop  = 1'b0;
      @(posedge clk);
      #1;
      reset_pulse();
      idle(2);

      // single block 0x1..0x19
      send_block(25, 64'h1);
      idle(30);

      // early restart: 10 words of A, then full block B
      send_block(10, 64'hA00);
      send_block(25, 64'hB00);
      idle(30);

      // orphan words
      for (int i = 0; i < 3; i++) push_word(1'b0, 64'h55 + 64'(i));
      idle(5);

      // backpressure: three blocks against a stalled permutation
      stop_mode = 1;
      idle(2);
      acc0 = accepts;
      fork
         for (int b = 0; b < 3; b++) send_block(25, 64'hC00 + 64'(b * 256));
         begin
            n = 0;
            while (!up_if.stop && n < 500) begin
               @(negedge clk);
               n++;
            end
            chk("full_after_accepts", 64'(accepts - acc0), 64'(DEPTH));
            repeat (5) @(negedge clk);
            stop_mode = 0;
         end
      join
      idle(60);

      // stall mid-block with alternating stopout
      stop_mode = 2;
      send_block(25, 64'hD00);
      send_block(25, 64'hD80);
      idle(80);
      stop_mode = 0;
      idle(2);

      // reset with one committed block and five partial words held
      stop_mode = 1;
      idle(2);
      send_block(25, 64'hE00);
      send_block(5, 64'hF00);
      idle(2);
      reset_pulse();
      stop_mode = 0;
      idle(2);
      send_block(25, 64'h100);
      idle(30);

      // randomized framing, gaps and backpressure
      for (int it = 0; it < 60; it++) begin
         int kind;
         stop_mode = ($urandom_range(0, 2) == 0) ? 0 : 3;
         kind = $urandom_range(0, 9);
         if (kind <= 6) begin
            send_block(25, {$urandom, $urandom});
         end else if (kind == 7) begin
            send_block($urandom_range(1, 24), {$urandom, $urandom});
         end else if (kind == 8) begin
            push_word(1'b0, {$urandom, $urandom});
         end else begin
            idle($urandom_range(1, 8));
         end
      end

      stop_mode = 0;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      idle(3);
      chk("final_drain", 64'(exp_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
